// File: rtl/uart_receive_param.sv
// uart_receive_param: parametrised UART receiver with 2-of-3 mid-bit voting
// and a first-word-fall-through frame FIFO with parity/framing/overrun flags.
module uart_receive_param #(
  parameter int CYCLES_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_serial_rx,
  input  logic                 i_rx_ready,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  localparam int H  = CYCLES_PER_BIT / 2;
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] C_PRE = CW'(H - 1);
  localparam logic [CW-1:0] C_MID = CW'(H);
  localparam logic [CW-1:0] C_DEC = CW'(H + 1);
  localparam logic [CW-1:0] C_END = CW'(CYCLES_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        c;
  logic [3:0]           idx;
  logic                 smp_a, smp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 vote, dec, wrap, ferr_next;
  logic                 push, pop, full, empty, do_push;
  logic [AW:0]          wp, rp;
  logic [EW-1:0]        mem [FIFO_DEPTH];

  assign rx_s      = sync[1];
  assign vote      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign dec       = c == C_DEC;
  assign wrap      = c == C_END;
  assign ferr_next = ferr | ~vote;
  // The frame is complete at the decision point of its last stop bit.
  assign push      = state == S_STOP && dec && idx == LAST_STOP;
  assign empty     = wp == rp;
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop       = o_rx_valid && i_rx_ready;
  assign do_push   = push && (!full || pop);
  assign o_rx_valid = !empty;
  assign {o_rx_data, o_parity_err, o_frame_err} = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) sync <= 2'b11;
    else sync <= {sync[0], i_serial_rx};

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (c == C_PRE) smp_a <= rx_s;
      if (c == C_MID) smp_b <= rx_s;
    end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      c     <= '0;
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      c <= (state == S_IDLE || state == S_WAIT_HIGH || wrap) ? '0 : c + 1'b1;
      case (state)
        S_IDLE:
          if (!rx_s) begin
            state <= S_START;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        S_START:
          if (dec && vote) begin
            state <= S_IDLE;
            c     <= '0;
          end else if (wrap) begin
            state <= S_DATA;
            idx   <= '0;
          end
        S_DATA: begin
          if (dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            idx <= idx + 1'b1;
            if (idx == LAST_DATA) begin
              state <= PARITY != 0 ? S_PAR : S_STOP;
              idx   <= '0;
            end
          end
        end
        S_PAR: begin
          if (dec) perr <= (^shreg ^ vote) != (PARITY == 1);
          if (wrap) state <= S_STOP;
        end
        S_STOP:
          if (push) begin
            state <= ferr_next ? S_WAIT_HIGH : S_IDLE;
            c     <= '0;
            idx   <= '0;
          end else begin
            if (dec) ferr <= ferr_next;
            if (wrap) idx <= idx + 1'b1;
          end
        // A held-low line must return high before another start bit is accepted.
        S_WAIT_HIGH: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wp        <= '0;
      rp        <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      o_overrun <= push && !do_push;
    end

  always_ff @(posedge i_clk)
    if (do_push) mem[wp[AW-1:0]] <= {shreg, perr, ferr_next};
endmodule
